wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone-style memory port (word address, byte selects, single-cycle ack) between NUM_MASTERS bus masters.
- Used for multi-core picorv32 configurations driving the shared memory model, with identical bus semantics on both sides.
- Adds a per-transaction ack timeout so a missing slave ack cannot hang the system.

Parameters:
- NUM_MASTERS, 2: number of requesting masters; must be ≥2.
- TIMEOUT_CYCLES, 64: BUSY cycles without s_ack before an error is raised; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_adr  in  NUM_MASTERS*30  word addresses [31:2]; master i occupies slice [30*i +: 30].
- m_dat  in  NUM_MASTERS*32  write data per master.
- m_sel  in  NUM_MASTERS*4  byte selects per master.
- m_we  in  NUM_MASTERS  write enable per master.
- m_cyc  in  NUM_MASTERS  request/cycle valid per master.
- m_rdt  out  32  read data, broadcast to all masters (equals s_rdt).
- m_ack  out  NUM_MASTERS  ack, routed to the granted master only.
- m_err  out  NUM_MASTERS  one-cycle timeout error pulse.
- s_adr  out  30  shared port word address.
- s_dat  out  32  shared port write data.
- s_sel  out  4  shared port byte selects.
- s_we  out  1  shared port write enable.
- s_cyc  out  1  shared port cycle valid.
- s_rdt  in  32  shared port read data.
- s_ack  in  1  shared port ack.
- grant  out  NUM_MASTERS  one-hot current owner; all zero when IDLE.

Behaviour:
- Reset (async, active-high), effective immediately:
  - State = IDLE; grant = 0; rr_ptr = 0; timeout counter = 0; m_err = 0.
  - s_cyc, m_ack, s_adr, s_dat, s_sel and s_we are combinationally 0.
- IDLE:
  - Any m_cyc set → search upward from rr_ptr (mod NUM_MASTERS) for the first master with m_cyc set.
  - Register its one-hot grant and go to BUSY; arbitration therefore costs 1 cycle.
  - No m_cyc set → stay in IDLE.
- BUSY, owner g:
  - Datapath, combinational: s_adr/s_dat/s_sel/s_we = master g's slices; s_cyc = m_cyc[g].
  - Ack routing, combinational and zero-latency: m_ack[g] = s_ack; all other m_ack bits are 0.
  - s_ack while BUSY → go to IDLE; rr_ptr = (g+1) mod NUM_MASTERS; grant clears on the same edge.
  - A master re-requesting therefore sees at least one dead cycle between transactions.
  - m_cyc[g] drops before ack (abort) → go to IDLE; rr_ptr advances as above; no m_ack, no m_err.
  - Timeout (TIMEOUT_CYCLES > 0): the counter increments on each BUSY cycle without s_ack.
    - When the count reaches TIMEOUT_CYCLES-1 with no ack, next edge: m_err[g] = 1 for exactly one cycle, go to IDLE, rr_ptr advances.
    - s_cyc falls combinationally with the leaving of BUSY.
  - The counter clears on entry to BUSY.
- Simultaneous events:
  - s_ack and timeout on the same cycle → ack wins; no m_err.
  - s_ack arriving while IDLE (late ack after an abort or timeout) is ignored and not routed.
- Fairness: each requesting master waits at most NUM_MASTERS-1 transactions.
- Non-owners are never acked; their requests stay pending (Wishbone stall-by-no-ack).
- grant is exactly one-hot or zero at all times.
- m_rdt = s_rdt unconditionally; masters qualify read data with m_ack.

Decomposition:
- Shared package wb_pkg holds:
  - WB_ADR_W = 30, WB_DAT_W = 32, WB_SEL_W = 4;
  - the state enum {ST_IDLE, ST_BUSY};
  - the slice-index helper for flattened master buses.
- One natural sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_MASTERS], rr_ptr. Output: one-hot pick.
  - Implement with the doubled-vector mask technique; unit-test standalone.
- The FSM, timeout counter and datapath muxing stay in wb_rr_arbiter.

Test Plan:
- Single master:
  - Stimulus: m_cyc[0] = 1, adr = 0x0000100, we = 0, slave acks 1 cycle after s_cyc.
  - Response: grant = 01 one cycle later; s_adr = 0x0000100; m_ack[0] pulses once; m_ack[1] stays 0; returns to IDLE.
- Contention:
  - Stimulus: both m_cyc rise together after reset, continuous requests, 6 transactions.
  - Response: grant order 01, 10, 01, 10, 01, 10; exactly one dead IDLE cycle between grants.
- Write forwarding:
  - Stimulus: master 1 writes dat = 0x000000AD, sel = 0xF, adr = 0x04000001.
  - Response: s_we = 1, s_dat = 0x000000AD, s_sel = 0xF while grant = 10; memory word updated.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, slave never acks master 0.
  - Response: m_err[0] is high for exactly one cycle, 4 cycles after grant; s_cyc drops; pending master 1 is granted next.
- Ack/timeout race and late ack:
  - Stimulus: s_ack asserted on the timeout cycle.
  - Response: m_ack pulses, no m_err.
  - Stimulus: s_ack asserted one cycle after an abort.
  - Response: no m_ack bit set.
- Reset mid-transaction:
  - Stimulus: assert reset asynchronously while BUSY with grant = 10.
  - Response: s_cyc, grant and m_ack go to 0 immediately; after release, master 0 wins the first tie.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the round-robin arbiter and its picker.
package wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } wb_state_e;

    // Lowest bit index of master idx's field in a flattened per-master bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is doubled and the
// bits below rr_ptr are masked off. The lowest remaining bit is the first
// requester at or above rr_ptr, with wrap-around. Folding the two halves
// together gives a one-hot result in master index space.
module rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [NUM_MASTERS-1:0] pick
);

    localparam int DW = 2 * NUM_MASTERS;

    logic [DW-1:0] req_dbl;
    logic [DW-1:0] keep_mask;
    logic [DW-1:0] masked;
    logic [DW-1:0] lowest;

    // Mask below the pointer, isolate the lowest set bit, fold to one-hot.
    always_comb begin
        req_dbl   = {req, req};
        keep_mask = ~((DW'(1) << rr_ptr) - DW'(1));
        masked    = req_dbl & keep_mask;
        lowest    = masked & (~masked + DW'(1));
        pick      = lowest[NUM_MASTERS-1:0] | lowest[DW-1:NUM_MASTERS];
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter that shares one Wishbone memory port between
// NUM_MASTERS masters. A per-transaction ack timeout stops a missing slave
// ack from hanging the bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; arbitrate among pending m_cyc and register grant
// ST_BUSY | owner drives the shared port; leave on ack, abort or timeout
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat,
    input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel,
    input  logic [NUM_MASTERS-1:0]          m_we,
    input  logic [NUM_MASTERS-1:0]          m_cyc,
    output logic [WB_DAT_W-1:0]             m_rdt,
    output logic [NUM_MASTERS-1:0]          m_ack,
    output logic [NUM_MASTERS-1:0]          m_err,
    output logic [WB_ADR_W-1:0]             s_adr,
    output logic [WB_DAT_W-1:0]             s_dat,
    output logic [WB_SEL_W-1:0]             s_sel,
    output logic                            s_we,
    output logic                            s_cyc,
    input  logic [WB_DAT_W-1:0]             s_rdt,
    input  logic                            s_ack,
    output logic [NUM_MASTERS-1:0]          grant
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    wb_state_e              state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] pick;
    logic [NUM_MASTERS-1:0] err_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       owner_idx;
    logic [PTR_W-1:0]       ptr_after;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   owner_cyc;
    logic                   timeout_hit;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .PTR_W       (PTR_W)
    ) u_rr_pick (
        .req    (m_cyc),
        .rr_ptr (rr_ptr_q),
        .pick   (pick)
    );

    // Owner index from the one-hot grant, and the pointer value after it.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
        ptr_after   = (owner_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_idx + PTR_W'(1);
        owner_cyc   = |(m_cyc & grant_q);
        timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);
    end

    // Next state: arbitrate in IDLE; in BUSY leave on ack, abort or timeout.
    // Ack has priority, so an ack on the timeout cycle raises no error.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        err_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|m_cyc) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (s_ack || !owner_cyc || timeout_hit) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ptr_after;
                    if (!s_ack && owner_cyc) begin
                        err_d = grant_q;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant, pointer, timeout counter and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            m_err    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            m_err    <= err_d;
        end
    end

    // Shared-port mux and ack routing. Both follow grant_q, which reset
    // clears at once, so the port goes quiet at once too.
    always_comb begin
        s_adr = '0;
        s_dat = '0;
        s_sel = '0;
        s_we  = 1'b0;
        s_cyc = 1'b0;
        if (state_q == ST_BUSY) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_q[i]) begin
                    s_adr = m_adr[slice_lo(i, WB_ADR_W) +: WB_ADR_W];
                    s_dat = m_dat[slice_lo(i, WB_DAT_W) +: WB_DAT_W];
                    s_sel = m_sel[slice_lo(i, WB_SEL_W) +: WB_SEL_W];
                    s_we  = m_we[i];
                    s_cyc = m_cyc[i];
                end
            end
        end
        m_ack = grant_q & {NUM_MASTERS{s_ack}};
        m_rdt = s_rdt;
        grant = grant_q;
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (2 masters, 4-cycle timeout) and a
// standalone 3-input rr_pick.
module tb_wb_rr_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*30-1:0] m_adr = '0;
    logic [N*32-1:0] m_dat = '0;
    logic [N*4-1:0]  m_sel = '0;
    logic [N-1:0]    m_we  = '0;
    logic [N-1:0]    m_cyc = '0;
    logic [31:0]     m_rdt;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic [29:0]     s_adr;
    logic [31:0]     s_dat;
    logic [3:0]      s_sel;
    logic            s_we;
    logic            s_cyc;
    logic [31:0]     s_rdt = '0;
    logic            s_ack = 1'b0;
    logic [N-1:0]    grant;

    logic [2:0] p_req = '0;
    logic [1:0] p_ptr = '0;
    logic [2:0] p_pick;

    logic [31:0] mem_word = 32'hFFFF_FFFF;

    int vectors     = 0;
    int miscompares = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .m_adr (m_adr),
        .m_dat (m_dat),
        .m_sel (m_sel),
        .m_we  (m_we),
        .m_cyc (m_cyc),
        .m_rdt (m_rdt),
        .m_ack (m_ack),
        .m_err (m_err),
        .s_adr (s_adr),
        .s_dat (s_dat),
        .s_sel (s_sel),
        .s_we  (s_we),
        .s_cyc (s_cyc),
        .s_rdt (s_rdt),
        .s_ack (s_ack),
        .grant (grant)
    );

    rr_pick #(
        .NUM_MASTERS (3),
        .PTR_W       (2)
    ) u_pick3 (
        .req    (p_req),
        .rr_ptr (p_ptr),
        .pick   (p_pick)
    );

    always #5 clk = ~clk;

    // One memory word at the write-test address, updated by byte lane on ack.
    always @(posedge clk) begin
        if (s_cyc && s_ack && s_we && s_adr == 30'h0400_0001) begin
            for (int b = 0; b < 4; b++) begin
                if (s_sel[b]) mem_word[8*b +: 8] <= s_dat[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", grant); end
        vectors++; if (s_cyc !== 1'b0) begin miscompares++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc); end
        vectors++; if (m_ack !== 2'b00) begin miscompares++; $display("FAIL reset_m_ack: got %b want 00", m_ack); end
        vectors++; if (m_err !== 2'b00) begin miscompares++; $display("FAIL reset_m_err: got %b want 00", m_err); end
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_release_grant: got %b want 00", grant); end
    endtask

    task automatic test_single_master();
        m_adr[0 +: 30] = 30'h000_0100;
        m_we  = 2'b00;
        m_sel[3:0] = 4'hF;
        m_cyc = 2'b01;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL single_arb_cycle: grant %b want 00", grant); end
        tick();
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", grant); end
        vectors++; if (s_adr !== 30'h000_0100) begin miscompares++; $display("FAIL single_s_adr: got %h want 0000100", s_adr); end
        vectors++; if (s_cyc !== 1'b1) begin miscompares++; $display("FAIL single_s_cyc: got %b want 1", s_cyc); end
        vectors++; if (m_ack !== 2'b00) begin miscompares++; $display("FAIL single_no_early_ack: got %b want 00", m_ack); end
        s_ack = 1'b1;
        s_rdt = 32'h1234_5678;
        #1;
        vectors++; if (m_ack !== 2'b01) begin miscompares++; $display("FAIL single_ack: got %b want 01", m_ack); end
        vectors++; if (m_rdt !== 32'h1234_5678) begin miscompares++; $display("FAIL single_rdt: got %h want 12345678", m_rdt); end
        tick();
        m_cyc = 2'b00;
        s_ack = 1'b0;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL single_idle_grant: got %b want 00", grant); end
        vectors++; if (s_cyc !== 1'b0 || m_ack !== 2'b00) begin miscompares++; $display("FAIL single_idle_bus: s_cyc %b m_ack %b want 0 00", s_cyc, m_ack); end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_we  = 2'b00;
        m_cyc = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            vectors++; if (grant !== exp) begin miscompares++; $display("FAIL contention_grant[%0d]: got %b want %b", k, grant, exp); end
            s_ack = 1'b1;
            #1;
            vectors++; if (m_ack !== exp) begin miscompares++; $display("FAIL contention_ack[%0d]: got %b want %b", k, m_ack, exp); end
            tick();
            s_ack = 1'b0;
            if (k == 5) m_cyc = 2'b00;
            #1;
            vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL contention_dead[%0d]: grant %b want 00", k, grant); end
        end
    endtask

    task automatic test_write_forward();
        m_adr[30 +: 30] = 30'h0400_0001;
        m_dat[32 +: 32] = 32'h0000_00AD;
        m_sel[4 +: 4]   = 4'hF;
        m_we  = 2'b10;
        m_cyc = 2'b10;
        tick();
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL write_grant: got %b want 10", grant); end
        vectors++; if (s_we !== 1'b1) begin miscompares++; $display("FAIL write_s_we: got %b want 1", s_we); end
        vectors++; if (s_dat !== 32'h0000_00AD) begin miscompares++; $display("FAIL write_s_dat: got %h want 000000ad", s_dat); end
        vectors++; if (s_sel !== 4'hF) begin miscompares++; $display("FAIL write_s_sel: got %h want f", s_sel); end
        vectors++; if (s_adr !== 30'h0400_0001) begin miscompares++; $display("FAIL write_s_adr: got %h want 4000001", s_adr); end
        s_ack = 1'b1;
        tick();
        m_cyc = 2'b00;
        m_we  = 2'b00;
        s_ack = 1'b0;
        #1;
        vectors++; if (mem_word !== 32'h0000_00AD) begin miscompares++; $display("FAIL write_mem: got %h want 000000ad", mem_word); end
    endtask

    task automatic test_timeout();
        m_cyc = 2'b11;
        tick();
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL timeout_grant: got %b want 01", grant); end
        for (int j = 1; j < TO; j++) begin
            tick();
            vectors++; if (m_err !== 2'b00 || grant !== 2'b01) begin miscompares++; $display("FAIL timeout_wait[%0d]: m_err %b grant %b want 00 01", j, m_err, grant); end
        end
        tick();
        vectors++; if (m_err !== 2'b01) begin miscompares++; $display("FAIL timeout_err: got %b want 01", m_err); end
        vectors++; if (s_cyc !== 1'b0 || grant !== 2'b00) begin miscompares++; $display("FAIL timeout_release: s_cyc %b grant %b want 0 00", s_cyc, grant); end
        tick();
        vectors++; if (m_err !== 2'b00) begin miscompares++; $display("FAIL timeout_err_width: got %b want 00", m_err); end
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL timeout_next_grant: got %b want 10", grant); end
        s_ack = 1'b1;
        #1;
        vectors++; if (m_ack !== 2'b10) begin miscompares++; $display("FAIL timeout_next_ack: got %b want 10", m_ack); end
        tick();
        s_ack = 1'b0;
        m_cyc = 2'b00;
    endtask

    task automatic test_race_and_late_ack();
        m_cyc = 2'b01;
        tick();
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL race_grant: got %b want 01", grant); end
        for (int j = 1; j < TO; j++) tick();
        s_ack = 1'b1;
        #1;
        vectors++; if (m_ack !== 2'b01) begin miscompares++; $display("FAIL race_ack: got %b want 01", m_ack); end
        tick();
        vectors++; if (m_err !== 2'b00 || grant !== 2'b00) begin miscompares++; $display("FAIL race_no_err: m_err %b grant %b want 00 00", m_err, grant); end
        m_cyc = 2'b10;
        s_ack = 1'b0;
        tick();
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL abort_grant: got %b want 10", grant); end
        m_cyc = 2'b00;
        #1;
        vectors++; if (s_cyc !== 1'b0) begin miscompares++; $display("FAIL abort_s_cyc: got %b want 0", s_cyc); end
        tick();
        vectors++; if (grant !== 2'b00 || m_err !== 2'b00) begin miscompares++; $display("FAIL abort_idle: grant %b m_err %b want 00 00", grant, m_err); end
        s_ack = 1'b1;
        #1;
        vectors++; if (m_ack !== 2'b00) begin miscompares++; $display("FAIL late_ack_routed: got %b want 00", m_ack); end
        tick();
        s_ack = 1'b0;
        vectors++; if (grant !== 2'b00 || m_err !== 2'b00) begin miscompares++; $display("FAIL late_ack_idle: grant %b m_err %b want 00 00", grant, m_err); end
    endtask

    task automatic test_reset_mid();
        m_cyc = 2'b10;
        tick();
        vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rstmid_grant: got %b want 10", grant); end
        s_ack = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rstmid_grant_clear: got %b want 00", grant); end
        vectors++; if (s_cyc !== 1'b0) begin miscompares++; $display("FAIL rstmid_s_cyc: got %b want 0", s_cyc); end
        vectors++; if (m_ack !== 2'b00) begin miscompares++; $display("FAIL rstmid_m_ack: got %b want 00", m_ack); end
        tick();
        reset = 1'b0;
        s_ack = 1'b0;
        m_cyc = 2'b11;
        tick();
        vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rstmid_tie: got %b want 01", grant); end
        m_cyc = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_rr_pick();
        logic [2:0] exp;
        int idx;
        for (int it = 0; it < 200; it++) begin
            p_req = 3'($urandom_range(0, 7));
            p_ptr = 2'($urandom_range(0, 2));
            #1;
            exp = '0;
            for (int off = 0; off < 3; off++) begin
                idx = (int'(p_ptr) + off) % 3;
                if (p_req[idx] && exp == 3'b000) exp[idx] = 1'b1;
            end
            vectors++; if (p_pick !== exp) begin miscompares++; $display("FAIL rr_pick req=%b ptr=%0d: got %b want %b", p_req, p_ptr, p_pick, exp); end
        end
    endtask

    // Randomized traffic against a transaction-level model: owner index,
    // next-priority index and busy-cycle count.
    task automatic test_random();
        int           owner;
        int           mptr;
        int           busy;
        int           cand;
        logic [N-1:0] exp_err;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ack;
        logic [N-1:0] done;
        logic         exp_cyc;
        logic [29:0]  exp_adr;
        logic         exp_we;

        m_cyc = '0;
        s_ack = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        owner   = -1;
        mptr    = 0;
        busy    = 0;
        exp_err = '0;

        for (int c = 0; c < 2000; c++) begin
            #1;
            exp_grant = '0;
            exp_ack   = '0;
            exp_cyc   = 1'b0;
            exp_adr   = '0;
            exp_we    = 1'b0;
            if (owner >= 0) begin
                exp_grant[owner] = 1'b1;
                exp_ack[owner]   = s_ack;
                exp_cyc          = m_cyc[owner];
                exp_adr          = m_adr[30*owner +: 30];
                exp_we           = m_we[owner];
            end
            vectors++; if (grant !== exp_grant) begin miscompares++; $display("FAIL rand_grant @%0d: got %b want %b", c, grant, exp_grant); end
            vectors++; if (m_ack !== exp_ack) begin miscompares++; $display("FAIL rand_ack @%0d: got %b want %b", c, m_ack, exp_ack); end
            vectors++; if (m_err !== exp_err) begin miscompares++; $display("FAIL rand_err @%0d: got %b want %b", c, m_err, exp_err); end
            vectors++; if (s_cyc !== exp_cyc || s_we !== exp_we) begin miscompares++; $display("FAIL rand_cyc_we @%0d: got %b%b want %b%b", c, s_cyc, s_we, exp_cyc, exp_we); end
            vectors++; if (s_adr !== exp_adr) begin miscompares++; $display("FAIL rand_adr @%0d: got %h want %h", c, s_adr, exp_adr); end
            vectors++; if (m_rdt !== s_rdt) begin miscompares++; $display("FAIL rand_rdt @%0d: got %h want %h", c, m_rdt, s_rdt); end

            @(posedge clk);
            exp_err = '0;
            done    = '0;
            if (owner < 0) begin
                cand = -1;
                for (int off = 0; off < N; off++) begin
                    if (cand < 0 && m_cyc[(mptr + off) % N]) cand = (mptr + off) % N;
                end
                if (cand >= 0) begin
                    owner = cand;
                    busy  = 0;
                end
            end else if (s_ack) begin
                done[owner] = 1'b1;
                mptr  = (owner + 1) % N;
                owner = -1;
            end else if (!m_cyc[owner]) begin
                mptr  = (owner + 1) % N;
                owner = -1;
            end else begin
                busy++;
                if (busy == TO) begin
                    exp_err[owner] = 1'b1;
                    done[owner]    = 1'b1;
                    mptr  = (owner + 1) % N;
                    owner = -1;
                end
            end

            #1;
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    m_cyc[i] = 1'b0;
                end else if (m_cyc[i]) begin
                    if ($urandom_range(0, 31) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc[i]         = 1'b1;
                    m_adr[30*i +: 30] = 30'($urandom);
                    m_dat[32*i +: 32] = $urandom;
                    m_sel[4*i +: 4]   = 4'($urandom);
                    m_we[i]          = 1'($urandom);
                end
            end
            s_ack = ($urandom_range(0, 3) == 0);
            s_rdt = $urandom;
        end
        m_cyc = '0;
        s_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_contention();
        test_write_forward();
        test_timeout();
        test_race_and_late_ack();
        test_reset_mid();
        test_rr_pick();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
